fpu_fcsr: RTL and testbench

- Consumer of the per-operation IEEE exception flags produced by the FPU exception stage.
- Accumulates those flags into the sticky accrued-flags register (fflags) and holds the dynamic rounding mode (frm).
- Provides a request/response CSR access port for fflags, frm and fcsr.
- Resolves the instruction rounding mode for the datapath.
- Sits between the FPU exception stage and the core CSR unit.

---
 rtl/fpu_fcsr.sv | 158 +++++++++++++++
 tb/tb_fpu_fcsr.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_fcsr.sv
// FPU control/status register: sticky accrued flags, dynamic rounding mode, CSR access port.
// Optional trap-enable register and trap_o output when FPU_FCSR_TRAP_EN is defined.
module fpu_fcsr #(
  parameter logic [11:0] CSR_FFLAGS_ADDR = 12'h001,
  parameter logic [11:0] CSR_FRM_ADDR    = 12'h002,
  parameter logic [11:0] CSR_FCSR_ADDR   = 12'h003,
  parameter logic [2:0]  RESET_FRM       = 3'b000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flags_valid_i,
  input  logic        invalid_i,
  input  logic        div_zero_i,
  input  logic        overflow_i,
  input  logic        underflow_i,
  input  logic        inexact_i,
  input  logic        csr_req_i,
  output logic        csr_ready_o,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_rvalid_o,
  output logic [31:0] csr_rdata_o,
  output logic        csr_err_o,
  input  logic [2:0]  instr_rm_i,
  output logic [2:0]  rm_o,
  output logic        rm_invalid_o,
  output logic [4:0]  fflags_o
`ifdef FPU_FCSR_TRAP_EN
  ,
  output logic        trap_o
`endif
);

  localparam int unsigned FLAGS_W = 5;
  localparam int unsigned FRM_W   = 3;
  localparam int unsigned FIELD_W = FRM_W + FLAGS_W;
  localparam int unsigned DATA_W  = 32;

  typedef enum logic {IDLE, RESP} state_e;

  function automatic logic [FIELD_W-1:0] apply_op(input logic [1:0]         op,
                                                  input logic [FIELD_W-1:0] old,
                                                  input logic [FIELD_W-1:0] wd);
    case (op)
      2'b01:   apply_op = wd;
      2'b10:   apply_op = old | wd;
      2'b11:   apply_op = old & ~wd;
      default: apply_op = old;
    endcase
  endfunction

  state_e               state_q;
  logic [FLAGS_W-1:0]   fflags_q, fflags_d, fflags_csr_c, incoming_c;
  logic [FRM_W-1:0]     frm_q, frm_d;
  logic                 ready_q, rvalid_q, err_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 accept_c, err_c;
  logic [FIELD_W-1:0]   old_c, res_c;
  logic                 unused_wdata_c;

`ifdef FPU_FCSR_TRAP_EN
  localparam logic [11:0] CSR_TRAP_EN_ADDR = 12'h800;
  logic [FLAGS_W-1:0]   te_q, te_d;
  logic                 trap_q;
`endif

  assign unused_wdata_c = ^csr_wdata_i[DATA_W-1:FIELD_W];
  assign accept_c       = csr_req_i & ready_q;
  assign incoming_c     = flags_valid_i ?
                          {invalid_i, div_zero_i, overflow_i, underflow_i, inexact_i} : '0;

  // Address decode and op application; hardware flags are OR-ed in after the CSR result.
  always_comb begin
    old_c        = '0;
    res_c        = '0;
    err_c        = 1'b0;
    fflags_csr_c = fflags_q;
    frm_d        = frm_q;
`ifdef FPU_FCSR_TRAP_EN
    te_d         = te_q;
`endif
    if (csr_addr_i == CSR_FFLAGS_ADDR) begin
      old_c = FIELD_W'(fflags_q);
      res_c = apply_op(csr_op_i, old_c, FIELD_W'(csr_wdata_i[FLAGS_W-1:0]));
      if (accept_c) fflags_csr_c = res_c[FLAGS_W-1:0];
    end else if (csr_addr_i == CSR_FRM_ADDR) begin
      old_c = FIELD_W'(frm_q);
      res_c = apply_op(csr_op_i, old_c, FIELD_W'(csr_wdata_i[FRM_W-1:0]));
      if (accept_c) frm_d = res_c[FRM_W-1:0];
    end else if (csr_addr_i == CSR_FCSR_ADDR) begin
      old_c = {frm_q, fflags_q};
      res_c = apply_op(csr_op_i, old_c, csr_wdata_i[FIELD_W-1:0]);
      if (accept_c) {frm_d, fflags_csr_c} = res_c;
`ifdef FPU_FCSR_TRAP_EN
    end else if (csr_addr_i == CSR_TRAP_EN_ADDR) begin
      old_c = FIELD_W'(te_q);
      res_c = apply_op(csr_op_i, old_c, FIELD_W'(csr_wdata_i[FLAGS_W-1:0]));
      if (accept_c) te_d = res_c[FLAGS_W-1:0];
`endif
    end else begin
      err_c = 1'b1;
    end
    fflags_d = fflags_csr_c | incoming_c;
  end

  // Register file plus IDLE/RESP access sequencing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      fflags_q <= '0;
      frm_q    <= RESET_FRM;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef FPU_FCSR_TRAP_EN
      te_q     <= '0;
      trap_q   <= 1'b0;
`endif
    end else begin
      fflags_q <= fflags_d;
      frm_q    <= frm_d;
`ifdef FPU_FCSR_TRAP_EN
      te_q     <= te_d;
      trap_q   <= |(incoming_c & te_q);
`endif
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            state_q  <= RESP;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b1;
            rdata_q  <= DATA_W'(old_c);
            err_q    <= err_c;
          end
        end
        default: begin
          state_q  <= IDLE;
          ready_q  <= 1'b1;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign csr_ready_o  = ready_q;
  assign csr_rvalid_o = rvalid_q;
  assign csr_rdata_o  = rdata_q;
  assign csr_err_o    = err_q;
  assign fflags_o     = fflags_q;
  assign rm_o         = (instr_rm_i == 3'b111) ? frm_q : instr_rm_i;
  assign rm_invalid_o = rm_o[2] & (rm_o[1] | rm_o[0]);
`ifdef FPU_FCSR_TRAP_EN
  assign trap_o       = trap_q;
`endif

endmodule

// File: tb/tb_fpu_fcsr.sv
// Scoreboard bench for fpu_fcsr: directed test-plan steps followed by random traffic,
// checked against an abstract register model.
module tb_fpu_fcsr;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flags_valid_i = 1'b0;
  logic        invalid_i = 1'b0, div_zero_i = 1'b0, overflow_i = 1'b0;
  logic        underflow_i = 1'b0, inexact_i = 1'b0;
  logic        csr_req_i = 1'b0;
  logic        csr_ready_o;
  logic [1:0]  csr_op_i = 2'b00;
  logic [11:0] csr_addr_i = 12'h000;
  logic [31:0] csr_wdata_i = 32'h0;
  logic        csr_rvalid_o;
  logic [31:0] csr_rdata_o;
  logic        csr_err_o;
  logic [2:0]  instr_rm_i = 3'b111;
  logic [2:0]  rm_o;
  logic        rm_invalid_o;
  logic [4:0]  fflags_o;
`ifdef FPU_FCSR_TRAP_EN
  logic        trap_o;
  localparam bit HAS_TE = 1'b1;
`else
  localparam bit HAS_TE = 1'b0;
`endif

  fpu_fcsr dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .flags_valid_i(flags_valid_i),
    .invalid_i    (invalid_i),
    .div_zero_i   (div_zero_i),
    .overflow_i   (overflow_i),
    .underflow_i  (underflow_i),
    .inexact_i    (inexact_i),
    .csr_req_i    (csr_req_i),
    .csr_ready_o  (csr_ready_o),
    .csr_op_i     (csr_op_i),
    .csr_addr_i   (csr_addr_i),
    .csr_wdata_i  (csr_wdata_i),
    .csr_rvalid_o (csr_rvalid_o),
    .csr_rdata_o  (csr_rdata_o),
    .csr_err_o    (csr_err_o),
    .instr_rm_i   (instr_rm_i),
    .rm_o         (rm_o),
    .rm_invalid_o (rm_invalid_o),
`ifdef FPU_FCSR_TRAP_EN
    .trap_o       (trap_o),
`endif
    .fflags_o     (fflags_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Abstract model state: plain integers for each architectural field.
  int m_ff = 0, m_frm = 0, m_te = 0, m_trap = 0;
  bit m_busy = 0;

  function automatic int app(input int op, input int old, input int wd);
    case (op)
      1:       return wd;
      2:       return old | wd;
      3:       return old & ~wd;
      default: return old;
    endcase
  endfunction

  // Model: compare current architectural outputs, then advance to the post-edge state.
  always @(negedge clk) begin
    int inc, nff, old, a, wd, op, exp_rm, r;
    bit err, nt;
    if (!rst_ni) begin
      check("rst_fflags", 32'(fflags_o), 0);
      check("rst_ready", 32'(csr_ready_o), 1);
      check("rst_rvalid", 32'(csr_rvalid_o), 0);
      check("rst_rdata", csr_rdata_o, 0);
      check("rst_err", 32'(csr_err_o), 0);
      m_ff = 0; m_frm = 0; m_te = 0; m_trap = 0; m_busy = 0;
      exp_q.delete();
    end else begin
      check("fflags", 32'(fflags_o), m_ff);
      check("ready", 32'(csr_ready_o), m_busy ? 0 : 1);
      check("rvalid", 32'(csr_rvalid_o), m_busy ? 1 : 0);
      exp_rm = (instr_rm_i == 3'b111) ? m_frm : int'(instr_rm_i);
      check("rm", 32'(rm_o), exp_rm);
      check("rm_invalid", 32'(rm_invalid_o), (exp_rm >= 5) ? 1 : 0);
`ifdef FPU_FCSR_TRAP_EN
      check("trap", 32'(trap_o), m_trap);
`endif
      inc = flags_valid_i ? (int'(invalid_i) * 16 + int'(div_zero_i) * 8 + int'(overflow_i) * 4
                             + int'(underflow_i) * 2 + int'(inexact_i)) : 0;
      nt = (inc & m_te) != 0;
      nff = m_ff;
      if (m_busy) begin
        m_busy = 0;
      end else if (csr_req_i) begin
        a = int'(csr_addr_i); wd = int'(csr_wdata_i); op = int'(csr_op_i);
        err = 0; old = 0;
        if (a == 1) begin
          old = m_ff; nff = app(op, old, wd & 31) & 31;
        end else if (a == 2) begin
          old = m_frm; m_frm = app(op, old, wd & 7) & 7;
        end else if (a == 3) begin
          old = m_frm * 32 + m_ff;
          r = app(op, old, wd & 255) & 255;
          m_frm = r / 32; nff = r % 32;
        end else if (HAS_TE && a == 'h800) begin
          old = m_te; m_te = app(op, old, wd & 31) & 31;
        end else begin
          err = 1;
        end
        exp_q.push_back({err, 32'(old)});
        m_busy = 1;
      end
      m_ff = nff | inc;
      m_trap = nt ? 1 : 0;
    end
  end

  // Monitor: pop the scoreboard whenever a response is presented.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_ni && csr_rvalid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 32'(csr_rvalid_o), 0);
      end else begin
        e = exp_q.pop_front();
        check("rdata", csr_rdata_o, e[31:0]);
        check("err", 32'(csr_err_o), 32'(e[32]));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_flags(input bit fv, input logic [4:0] f);
    flags_valid_i = fv;
    {invalid_i, div_zero_i, overflow_i, underflow_i, inexact_i} = f;
  endtask

  task automatic csr_access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                            input bit fv, input logic [4:0] f);
    tick();
    for (int i = 0; i < 8 && !csr_ready_o; i++) tick();
    if (!csr_ready_o) check("ready_timeout", 32'(csr_ready_o), 1);
    csr_req_i = 1'b1; csr_op_i = op; csr_addr_i = addr; csr_wdata_i = wd;
    set_flags(fv, f);
    tick();
    csr_req_i = 1'b0;
    set_flags(1'b0, 5'h0);
  endtask

  task automatic pulse_flags(input logic [4:0] f);
    tick();
    set_flags(1'b1, f);
    tick();
    set_flags(1'b0, 5'h0);
  endtask

  initial begin
    bit acc;
    int pick;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Test-plan steps; the model checks every cycle.
    csr_access(2'b00, 12'h001, 32'h0, 1'b0, 5'h0);
    pulse_flags(5'b00101);
    pulse_flags(5'b10000);
    tick();
    check("ff_after_pulses", 32'(fflags_o), 32'h15);
    csr_access(2'b00, 12'h003, 32'h0, 1'b0, 5'h0);
    csr_access(2'b01, 12'h003, 32'hE3, 1'b0, 5'h0);
    tick();
    instr_rm_i = 3'b111; tick();
    check("rm_dyn_reserved", 32'(rm_o), 32'h7);
    instr_rm_i = 3'b010; tick();
    check("rm_static", 32'(rm_o), 32'h2);
    csr_access(2'b01, 12'h001, 32'h1, 1'b0, 5'h0);
    csr_access(2'b11, 12'h001, 32'h1F, 1'b1, 5'b01000);
    tick();
    check("ff_clear_vs_hw", 32'(fflags_o), 32'h08);
    csr_access(2'b01, 12'h800, 32'h1F, 1'b0, 5'h0);

    // Back-to-back: second request held through RESP, then to an illegal address.
    tick();
    csr_req_i = 1'b1; csr_op_i = 2'b00; csr_addr_i = 12'h003;
    tick();
    csr_op_i = 2'b01; csr_addr_i = 12'h7C0; csr_wdata_i = 32'hFFFF_FFFF;
    check("b2b_not_ready", 32'(csr_ready_o), 0);
    tick();
    tick();
    csr_req_i = 1'b0;

    // Random traffic with request holding.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = csr_req_i && csr_ready_o;
      tick();
      if (!csr_req_i || acc) begin
        csr_req_i = ($urandom_range(0, 1) == 1);
        csr_op_i = 2'($urandom_range(0, 3));
        pick = $urandom_range(0, 4);
        csr_addr_i = (pick == 0) ? 12'h001 : (pick == 1) ? 12'h002 : (pick == 2) ? 12'h003 :
                     (pick == 3) ? 12'h800 : 12'($urandom);
        csr_wdata_i = $urandom;
      end
      set_flags($urandom_range(0, 2) == 0, 5'($urandom));
      instr_rm_i = 3'($urandom);
    end
    tick();
    csr_req_i = 1'b0;
    set_flags(1'b0, 5'h0);
    repeat (3) tick();

    // Reset while a response is outstanding.
    csr_access(2'b01, 12'h003, 32'hFF, 1'b0, 5'h0);
    tick();
    csr_req_i = 1'b1; csr_op_i = 2'b10; csr_addr_i = 12'h002; csr_wdata_i = 32'h5;
    tick();
    rst_ni = 1'b0;
    csr_req_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    instr_rm_i = 3'b111;
    csr_access(2'b00, 12'h003, 32'h0, 1'b0, 5'h0);
    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
